glyph_mem_arbiter: RTL
======================

# glyph_mem_arbiter

Shares the single-port glyph BRAM between the LCD pixel read path and a UART-driven glyph loader. The block parses 4-byte write frames from the UART receiver and queues them in a small write FIFO. It then grants the BRAM port each cycle: display reads take priority, and queued writes drain in idle cycles. It sits between `uart_rx`, the pixel-address logic feeding `st7735`, and `bram`.

## Interface
Parameters:
- `WIDTH`, 4, BRAM word width
- `LEN`, 2000, BRAM depth in words
- `AW`, 11, address width (must satisfy 2**AW >= LEN, AW <= 16)
- `FIFO_DEPTH`, 4, write FIFO entries (power of two)
- `STARVE_LIMIT`, 64, cycles a pending write may wait before forced grant (used only with guard enabled)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `rx_ready`  in  1  one-cycle strobe, `rx_data` valid
- `rx_data`  in  8  received byte
- `rd_req`  in  1  display read request this cycle
- `rd_addr`  in  AW  display read address
- `rd_valid`  out  1  `rd_data` valid (one cycle after granted `rd_req`)
- `rd_data`  out  WIDTH  read word
- `mem_addr`  out  AW  to BRAM `addr`
- `mem_din`  out  WIDTH  to BRAM `din`
- `mem_we`  out  1  to BRAM `we`
- `mem_dout`  in  WIDTH  from BRAM `dout` (registered, 1-cycle latency)
- `wr_full`  out  1  write FIFO full
- `drop_count`  out  8  saturating count of discarded frames

## Operation
- Frame format: `0xA5`, addr_hi, addr_lo, data.
  - Address = {addr_hi, addr_lo}[AW-1:0]; upper bits of addr_hi are ignored.
  - Data = data[WIDTH-1:0].
- Parser FSM states: IDLE, ADDR_HI, ADDR_LO, DATA. Each `rx_ready` advances one state.
  - IDLE: `0xA5` → ADDR_HI; any other byte is ignored and the FSM stays in IDLE.
  - ADDR_HI → ADDR_LO → DATA: bytes are positional. `0xA5` mid-frame is treated as data, with no resync.
  - DATA: the frame completes and the FSM returns to IDLE. The frame is pushed to the FIFO if address < LEN and the FIFO has room.
  - Otherwise the frame is discarded and `drop_count` increments, saturating at 255.
- Arbitration (combinational, per cycle):
  - `rd_req` high: `mem_addr`=`rd_addr`, `mem_we`=0. `rd_valid`=1 on the next cycle with `rd_data`=`mem_dout`.
  - Else, if the FIFO is non-empty: `mem_addr`/`mem_din` come from the FIFO head, `mem_we`=1, and the head is popped.
  - Else: `mem_we`=0, `mem_addr` holds `rd_addr`.
- A FIFO push and pop in the same cycle are both allowed. "Room" means count < FIFO_DEPTH, or a pop occurs in the same cycle.
- Reset values: FSM=IDLE, FIFO empty, `rd_valid`=0, `drop_count`=0, `mem_we`=0. `mem_we` is also forced to 0 during every cycle `rst` is high.
- Reset mid-frame discards the partial frame and all queued writes, and does not count them as drops.

## Timing
- Read latency: 1 cycle. A grant in cycle N gives `rd_valid`/`rd_data` in cycle N+1. Back-to-back reads stream at 1 word/cycle.
- Write latency: the frame's data byte at cycle N gives a FIFO push at N+1. The earliest BRAM write is at N+1 only if the FIFO was empty and `rd_req`=0. The push is registered at the end of N; a pass-through write in the same cycle is permitted but not required.
- A write never issues while `rd_req`=1, unless the guard below forces it.
- `wr_full`: combinational from the FIFO count.

## Configuration
- `GLYPH_WR_STARVE_GUARD_EN` defined:
  - A counter increments each cycle the FIFO is non-empty and no write is granted.
  - When the counter reaches STARVE_LIMIT, the next cycle grants the write even if `rd_req`=1. That read is not served: `rd_valid`=0 in the following cycle.
  - The counter clears on any write grant or when the FIFO is empty.
- Undefined: strict read priority. Writes may starve indefinitely, and there is no counter logic.

## Structure
- Package `glyph_pkg`:
  - `SYNC_BYTE` = 8'hA5
  - parser state enum `glyph_parse_state_t`
  - default `AW`/`WIDTH`/`LEN` constants
- Sub-module `glyph_wr_fifo`: synchronous FIFO of {addr, data}, FIFO_DEPTH entries, with push/pop/full/empty/count. The parser, arbiter and guard stay in the top block.

## Test plan
- Reset, then bytes A5 01 2C 07 with `rd_req`=0 → one cycle with `mem_we`=1, `mem_addr`=300, `mem_din`=7. `drop_count`=0.
- Stream `rd_req`=1 at addresses 0..9 with BRAM model preloaded → `rd_valid` high 10 consecutive cycles, each `rd_data` matching the model one cycle after its address.
- Bytes A5 07 D0 03 (address 2000 ≥ LEN) → no write, `drop_count`=1. Bytes 3C 11 (no sync) → ignored, FSM stays IDLE.
- Hold `rd_req`=1 and send 5 valid frames with FIFO_DEPTH=4 → `wr_full`=1 after the 4th, 5th frame dropped (`drop_count`=1). Releasing `rd_req` → exactly 4 writes on consecutive cycles.
- With `GLYPH_WR_STARVE_GUARD_EN`, STARVE_LIMIT=64, `rd_req` held high and one queued frame → write granted on the 65th cycle after enqueue, `rd_valid`=0 for that slot only.
- Assert `rst` after A5 01 → FSM IDLE. Then 2C 07 → ignored, no write.

Source files
------------

// File: rtl/glyph_pkg.sv
// Shared constants, parser state type and frame helper for the glyph BRAM arbiter.
package glyph_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LEN   = 2000;
    localparam int DEF_AW    = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_DATA
    } glyph_parse_state_t;

    // Full 16-bit frame address; callers truncate to their address width.
    function automatic logic [15:0] frame_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/glyph_wr_fifo.sv
// Synchronous FIFO of pending glyph writes ({addr, data}); DEPTH is a power of two >= 2.
module glyph_wr_fifo #(
    parameter int AW    = 11,
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [AW-1:0]    push_addr,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [AW-1:0]    head_addr,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [AW+WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                do_push;
    logic                do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: the storage array has no reset; validity is tracked by count, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_addr, push_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign {head_addr, head_data} = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/glyph_mem_arbiter.sv
// Shares the glyph BRAM between display reads and UART-loaded writes (A5, hi, lo, data frames).
// Define GLYPH_WR_STARVE_GUARD_EN to force a queued write through after STARVE_LIMIT blocked cycles.
module glyph_mem_arbiter
    import glyph_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int LEN          = DEF_LEN,
    parameter int AW           = DEF_AW,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_din,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_dout,
    output logic             wr_full,
    output logic [7:0]       drop_count
);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0] LEN_LIM = (AW+1)'(LEN);

    glyph_parse_state_t state;
    logic [7:0]       addr_hi;
    logic [AW-1:0]    rx_addr;
    logic             frame_vld;
    logic             frame_ok;
    logic [AW-1:0]    frame_addr;
    logic [WIDTH-1:0] frame_data;

    assign rx_addr = AW'(frame_word(addr_hi, rx_data));

    // NOTE: sequential state uses <= so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_hi    <= '0;
            frame_vld  <= 1'b0;
            frame_ok   <= 1'b0;
            frame_addr <= '0;
            frame_data <= '0;
        end else begin
            frame_vld <= 1'b0;
            if (rx_ready) begin
                case (state)
                    ST_IDLE: if (rx_data == SYNC_BYTE) state <= ST_ADDR_HI;
                    ST_ADDR_HI: begin
                        addr_hi <= rx_data;
                        state   <= ST_ADDR_LO;
                    end
                    ST_ADDR_LO: begin
                        frame_addr <= rx_addr;
                        frame_ok   <= ({1'b0, rx_addr} < LEN_LIM);
                        state      <= ST_DATA;
                    end
                    ST_DATA: begin
                        frame_data <= rx_data[WIDTH-1:0];
                        frame_vld  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    logic             push, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [AW-1:0]    head_addr;
    logic [WIDTH-1:0] head_data;
    logic             grant_wr, grant_rd, force_wr;

    // A same-cycle pop frees the slot the completed frame needs.
    assign push = frame_vld && frame_ok && (!fifo_full || pop);
    assign drop = frame_vld && !push;

    glyph_wr_fifo #(
        .AW    (AW),
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (frame_addr),
        .push_data (frame_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign wr_full = (fifo_count == CW'(FIFO_DEPTH));

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst) begin
            grant_wr = !fifo_empty && (!rd_req || force_wr);
            grant_rd = rd_req && !grant_wr;
        end
        mem_we   = grant_wr;
        mem_addr = grant_wr ? head_addr : rd_addr;
        mem_din  = head_data;
        pop      = grant_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid   <= 1'b0;
            drop_count <= '0;
        end else begin
            rd_valid <= grant_rd;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    // BRAM output is already registered, so read data passes straight through.
    assign rd_data = mem_dout;

`ifdef GLYPH_WR_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (rst || fifo_empty || grant_wr) starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
    end

    assign force_wr = (starve_cnt == SW'(STARVE_LIMIT));
`else
    assign force_wr = 1'b0;
`endif

endmodule
